// File: rtl/bidir_bus_arbiter.sv
// Round-robin arbiter sharing one bidirectional pad bus between NREQ requesters.
// Each grant is either a drive phase (pad enabled) or a sample phase (pad read back).
module bidir_bus_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TURN    = 2,
    parameter int MAXHOLD = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        REQ,
    input  logic [NREQ-1:0]        REQ_WR,
    input  logic [NREQ*WIDTH-1:0]  DOUT,
    output logic [NREQ-1:0]        GNT,
    output logic [WIDTH-1:0]       PAD_I,
    output logic [WIDTH-1:0]       PAD_T,
    input  logic [WIDTH-1:0]       PAD_O,
    output logic [WIDTH-1:0]       RD_DATA,
    output logic                   RD_VALID,
    output logic [2:0]             RD_ID,
    output logic                   BUSY
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        TURNAROUND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic             wr_q, wr_d;
    logic [7:0]       hold_q, hold_d;
    logic [3:0]       turn_q, turn_d;
    logic [2:0]       last_q, last_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic [2:0]       rd_id_q, rd_id_d;

    logic [NREQ-1:0]  sel_oh;
    logic [WIDTH-1:0] sel_dout;
    logic             req_sel;
    logic [2:0]       pick;
    logic             pick_wr;
    logic             found;
    logic             drive;

    always_comb begin
        sel_oh   = '0;
        sel_dout = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_q == 3'(i)) begin
                sel_oh[i] = 1'b1;
                sel_dout  = DOUT[i*WIDTH +: WIDTH];
            end
        end
    end

    assign req_sel = |(REQ & sel_oh);

    // Search starts one past the previous owner, so a released owner goes last.
    always_comb begin
        pick    = last_q;
        pick_wr = 1'b0;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && REQ[i] && (((int'(last_q) + k) % NREQ) == i)) begin
                    found   = 1'b1;
                    pick    = 3'(i);
                    pick_wr = REQ_WR[i];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        wr_d       = wr_q;
        hold_d     = hold_q;
        turn_d     = turn_q;
        last_d     = last_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_id_d    = rd_id_q;
        case (state_q)
            IDLE: begin
                if (|REQ) begin
                    sel_d   = pick;
                    wr_d    = pick_wr;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                hold_d = hold_q + 8'd1;
                if (!wr_q) begin
                    rd_data_d  = PAD_O;
                    rd_valid_d = 1'b1;
                    rd_id_d    = sel_q;
                end
                if (!req_sel || (hold_q + 8'd1 == 8'(MAXHOLD))) begin
                    last_d  = sel_q;
                    turn_d  = '0;
                    state_d = (wr_q && TURN > 0) ? TURNAROUND : IDLE;
                end
            end
            TURNAROUND: begin
                turn_d = turn_q + 4'd1;
                if (turn_q + 4'd1 == 4'(TURN)) begin
                    turn_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            wr_q       <= 1'b0;
            hold_q     <= '0;
            turn_q     <= '0;
            last_q     <= 3'(NREQ - 1);
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            wr_q       <= wr_d;
            hold_q     <= hold_d;
            turn_q     <= turn_d;
            last_q     <= last_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
        end
    end

    // Pad control decodes straight from the state flop so reset releases it at once.
    assign drive    = (state_q == GRANT) && wr_q;
    assign GNT      = (state_q == GRANT) ? sel_oh : '0;
    assign PAD_T    = drive ? '0 : '1;
    assign PAD_I    = drive ? sel_dout : '0;
    assign BUSY     = (state_q != IDLE);
    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
    assign RD_ID    = rd_id_q;

endmodule
